// File: rtl/iir_filter_gen_pkg.sv
// Shared helpers for the generic IIR filter: width derivation, coefficient
// map constants and the saturate-and-flag function.
package iir_gen_pkg;

    // Working width of the saturation helper; accumulators must fit in it.
    localparam int SAT_W = 64;

    // Feed-forward taps start at index 0 of the coefficient map.
    localparam int B_BASE = 0;

    typedef struct packed {
        logic signed [SAT_W-1:0] y;
        logic                    sat;
    } sat_t;

    function automatic int clog2(input int v);
        int r;
        int t;
        r = 0;
        t = v - 1;
        while (t > 0) begin
            r = r + 1;
            t = t >> 1;
        end
        return r;
    endfunction

    // Feedback taps follow the ORDER+1 feed-forward taps.
    function automatic int a_base(input int order);
        return order + 1;
    endfunction

    function automatic int aw(input int order);
        return clog2(2 * order + 1);
    endfunction

    // Products are full precision, and there is headroom for summing all taps.
    function automatic int accw(input int dw, input int cw, input int order);
        return dw + cw + clog2(2 * order + 1);
    endfunction

    // Clamp v into the signed dw-bit range and report whether it had to clamp.
    function automatic sat_t sat_fn(input logic signed [SAT_W-1:0] v, input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t r;
        hi = $signed(64'd1 << (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.sat = 1'b1;
        if (v > hi) begin
            r.y = hi;
        end else if (v < lo) begin
            r.y = lo;
        end else begin
            r.y   = v;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Shadow/active coefficient storage. Writes land in the shadow bank; a commit
// copies the whole shadow bank into the active bank in one edge.
module iir_coef_bank
    import iir_gen_pkg::*;
#(
    parameter int CW    = 13,
    parameter int ORDER = 2,
    localparam int AW   = aw(ORDER)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cWe,
    input  logic [AW-1:0]               cAddr,
    input  logic [CW-1:0]               cData,
    input  logic                        cCommit,
    output logic [ORDER:0][CW-1:0]      b,
    output logic [ORDER-1:0][CW-1:0]    a
);

    localparam int NTAP = 2 * ORDER + 1;
    localparam int ABASE = a_base(ORDER);

    logic [NTAP-1:0][CW-1:0] shadow;
    logic [NTAP-1:0][CW-1:0] active;

    // Commit reads the shadow value from before any same-cycle write, so a
    // write and a commit together leave the new value pending in shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (cCommit) begin
                active <= shadow;
            end
            for (int i = 0; i < NTAP; i++) begin
                if (cWe && (cAddr == AW'(i))) begin
                    shadow[i] <= cData;
                end
            end
        end
    end

    // Split the active bank into b0..bORDER and a1..aORDER (a[k-1] holds ak).
    always_comb begin
        b = '0;
        a = '0;
        for (int k = 0; k <= ORDER; k++) begin
            b[k] = active[B_BASE + k];
        end
        for (int k = 0; k < ORDER; k++) begin
            a[k] = active[ABASE + k];
        end
    end

endmodule

// File: rtl/iir_filter_gen.sv
// Direct-form-I IIR filter with runtime coefficients, bypass, history clear
// and a sticky saturation flag. One sample per cycle, one cycle latency.
module iir_filter_gen
    import iir_gen_pkg::*;
#(
    parameter int DW    = 13,
    parameter int CW    = 13,
    parameter int FRAC  = 11,
    parameter int ORDER = 2,
    localparam int AW   = aw(ORDER)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vIn,
    input  logic [DW-1:0]        dIn,
    input  logic                 cWe,
    input  logic [AW-1:0]        cAddr,
    input  logic [CW-1:0]        cData,
    input  logic                 cCommit,
    input  logic                 bypass,
    input  logic                 clr,
    output logic [DW-1:0]        dOut,
    output logic                 vOut,
    output logic                 ovf
);

    localparam int ACCW = accw(DW, CW, ORDER);

    logic [ORDER:0][CW-1:0]   b;
    logic [ORDER-1:0][CW-1:0] a;

    // x_d[k] = x[n-k], y_d[k] = y[n-k]
    logic [ORDER:1][DW-1:0]   x_d;
    logic [ORDER:1][DW-1:0]   y_d;
    logic [ORDER:1][DW-1:0]   hx;
    logic [ORDER:1][DW-1:0]   hy;
    logic [ORDER:1][DW-1:0]   nx;
    logic [ORDER:1][DW-1:0]   ny;

    logic signed [ACCW-1:0]   acc;
    logic signed [ACCW-1:0]   y_sh;
    sat_t                     sr;
    logic signed [DW-1:0]     y_new;

    iir_coef_bank #(
        .CW    (CW),
        .ORDER (ORDER)
    ) u_coef (
        .clk     (clk),
        .rst     (rst),
        .cWe     (cWe),
        .cAddr   (cAddr),
        .cData   (cData),
        .cCommit (cCommit),
        .b       (b),
        .a       (a)
    );

    function automatic logic signed [ACCW-1:0] mac_term(
        input logic signed [CW-1:0] c,
        input logic signed [DW-1:0] d
    );
        return ACCW'(c) * ACCW'(d);
    endfunction

    // Clearing in the same cycle as a sample means the sample sees no history.
    always_comb begin
        hx = clr ? '0 : x_d;
        hy = clr ? '0 : y_d;
    end

    // MAC tree over the current sample and the (possibly cleared) history.
    always_comb begin
        acc = mac_term(b[0], dIn);
        for (int k = 1; k <= ORDER; k++) begin
            acc = acc + mac_term(b[k], hx[k]) - mac_term(a[k-1], hy[k]);
        end
        y_sh  = acc >>> FRAC;
        sr    = sat_fn(SAT_W'(y_sh), DW);
        y_new = DW'(sr.y);
    end

    // Next delay-line contents; bypass feeds dIn into both lines so the
    // recursion resumes from a consistent history when bypass drops.
    always_comb begin
        nx    = '0;
        ny    = '0;
        nx[1] = dIn;
        ny[1] = bypass ? dIn : y_new;
        for (int k = 2; k <= ORDER; k++) begin
            nx[k] = hx[k-1];
            ny[k] = hy[k-1];
        end
    end

    // Output and history registers; idle cycles hold everything except vOut.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_d  <= '0;
            y_d  <= '0;
            dOut <= '0;
            vOut <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            vOut <= vIn;
            if (vIn) begin
                x_d  <= nx;
                y_d  <= ny;
                dOut <= bypass ? dIn : y_new;
                if (!bypass && sr.sat) begin
                    ovf <= 1'b1;
                end
            end else if (clr) begin
                x_d <= '0;
                y_d <= '0;
            end
        end
    end

endmodule

// File: tb/tb_iir_filter_gen.sv
// Scenario bench for iir_filter_gen at DW=13, CW=13, FRAC=11, ORDER=2.
module tb_iir_filter_gen;

    localparam int DW = 13;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 vIn = 1'b0;
    logic signed [DW-1:0] dIn = '0;
    logic                 cWe = 1'b0;
    logic [2:0]           cAddr = '0;
    logic signed [12:0]   cData = '0;
    logic                 cCommit = 1'b0;
    logic                 bypass = 1'b0;
    logic                 clr = 1'b0;
    logic signed [DW-1:0] dOut;
    logic                 vOut;
    logic                 ovf;

    int total = 0;
    int bad   = 0;
    logic signed [DW-1:0] sb[$];

    always #5 clk = ~clk;

    iir_filter_gen dut (
        .clk     (clk),
        .rst     (rst),
        .vIn     (vIn),
        .dIn     (dIn),
        .cWe     (cWe),
        .cAddr   (cAddr),
        .cData   (cData),
        .cCommit (cCommit),
        .bypass  (bypass),
        .clr     (clr),
        .dOut    (dOut),
        .vOut    (vOut),
        .ovf     (ovf)
    );

    // One clock: apply the inputs, step past the edge, drop the strobes.
    task automatic cyc(input logic v, input logic signed [DW-1:0] x);
        vIn = v;
        dIn = x;
        @(posedge clk);
        #1;
        vIn = 1'b0;
        dIn = '0;
        cWe = 1'b0;
        cCommit = 1'b0;
        clr = 1'b0;
    endtask

    task automatic wcoef(input logic [2:0] ad, input logic signed [12:0] val);
        cWe = 1'b1;
        cAddr = ad;
        cData = val;
        cyc(1'b0, '0);
    endtask

    task automatic commit();
        cCommit = 1'b1;
        cyc(1'b0, '0);
    endtask

    task automatic test_reset();
        logic signed [DW-1:0] e;
        rst = 1'b1;
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        total++;
        if (dOut !== 0 || vOut !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_state dOut=%0d vOut=%b ovf=%b want 0/0/0", dOut, vOut, ovf);
        end
        rst = 1'b0;
        sb.push_back(13'sd0);
        cyc(1'b1, 13'sd500);
        e = sb.pop_front();
        total++;
        if (vOut !== 1'b1 || dOut !== e) begin
            bad++;
            $display("FAIL reset_zero_coef vOut=%b dOut=%0d want 1/%0d", vOut, dOut, e);
        end
    endtask

    task automatic test_identity();
        logic signed [DW-1:0] xs[3];
        logic signed [DW-1:0] e;
        xs = '{13'sd100, -13'sd50, 13'sd4095};
        wcoef(3'd0, 13'sd2048);
        commit();
        foreach (xs[i]) begin
            sb.push_back(xs[i]);
            cyc(1'b1, xs[i]);
            e = sb.pop_front();
            total++;
            if (vOut !== 1'b1 || dOut !== e || ovf !== 1'b0) begin
                bad++;
                $display("FAIL identity[%0d] vOut=%b dOut=%0d ovf=%b want 1/%0d/0", i, vOut, dOut, ovf, e);
            end
        end
        cyc(1'b0, '0);
        total++;
        if (vOut !== 1'b0 || dOut !== 13'sd4095) begin
            bad++;
            $display("FAIL identity_idle vOut=%b dOut=%0d want 0/4095", vOut, dOut);
        end
    endtask

    task automatic test_recursion();
        logic signed [DW-1:0] xs[6];
        logic signed [DW-1:0] ex[6];
        logic signed [DW-1:0] e;
        xs = '{13'sd2000, 13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0};
        ex = '{13'sd1000, 13'sd500, 13'sd250, 13'sd125, 13'sd62, 13'sd31};
        wcoef(3'd0, 13'sd1024);
        wcoef(3'd3, -13'sd1024);
        commit();
        clr = 1'b1;
        cyc(1'b0, '0);
        foreach (xs[i]) begin
            if (i == 3) begin
                for (int j = 0; j < 3; j++) begin
                    cyc(1'b0, '0);
                    total++;
                    if (vOut !== 1'b0 || dOut !== 13'sd250) begin
                        bad++;
                        $display("FAIL recur_idle[%0d] vOut=%b dOut=%0d want 0/250", j, vOut, dOut);
                    end
                end
            end
            sb.push_back(ex[i]);
            cyc(1'b1, xs[i]);
            e = sb.pop_front();
            total++;
            if (vOut !== 1'b1 || dOut !== e) begin
                bad++;
                $display("FAIL recur[%0d] vOut=%b dOut=%0d want 1/%0d", i, vOut, dOut, e);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [DW-1:0] xs[3];
        logic signed [DW-1:0] ex[3];
        logic signed [DW-1:0] e;
        xs = '{13'sd4000, -13'sd4096, 13'sd0};
        ex = '{13'sd4095, -13'sd4096, 13'sd0};
        wcoef(3'd0, 13'sd4095);
        wcoef(3'd3, 13'sd0);
        commit();
        clr = 1'b1;
        cyc(1'b0, '0);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL sat_pre ovf=%b want 0", ovf);
        end
        foreach (xs[i]) begin
            sb.push_back(ex[i]);
            cyc(1'b1, xs[i]);
            e = sb.pop_front();
            total++;
            if (vOut !== 1'b1 || dOut !== e || ovf !== 1'b1) begin
                bad++;
                $display("FAIL sat[%0d] vOut=%b dOut=%0d ovf=%b want 1/%0d/1", i, vOut, dOut, ovf, e);
            end
        end
    endtask

    task automatic test_commit();
        logic signed [DW-1:0] ex[5];
        logic signed [DW-1:0] e;
        ex = '{13'sd800, 13'sd400, 13'sd400, 13'sd800, 13'sd800};
        wcoef(3'd0, 13'sd2048);
        commit();
        wcoef(3'd0, 13'sd1024);
        clr = 1'b1;
        cyc(1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) cCommit = 1'b1;
            if (i == 2) begin
                cWe = 1'b1;
                cAddr = 3'd0;
                cData = 13'sd2048;
                commit();
            end
            if (i == 3) commit();
            if (i == 4) begin
                wcoef(3'd5, 13'sd1024);
                commit();
            end
            sb.push_back(ex[i]);
            cyc(1'b1, 13'sd800);
            e = sb.pop_front();
            total++;
            if (vOut !== 1'b1 || dOut !== e) begin
                bad++;
                $display("FAIL commit[%0d] vOut=%b dOut=%0d want 1/%0d", i, vOut, dOut, e);
            end
        end
    endtask

    task automatic test_clr_bypass();
        logic signed [DW-1:0] xs[5];
        logic signed [DW-1:0] ex[5];
        logic signed [DW-1:0] e;
        xs = '{13'sd2000, 13'sd0, 13'sd0, -13'sd7, 13'sd0};
        ex = '{13'sd1000, 13'sd500, 13'sd0, -13'sd7, -13'sd4};
        wcoef(3'd0, 13'sd1024);
        wcoef(3'd3, -13'sd1024);
        commit();
        clr = 1'b1;
        cyc(1'b0, '0);
        foreach (xs[i]) begin
            clr = (i == 2);
            bypass = (i == 3);
            sb.push_back(ex[i]);
            cyc(1'b1, xs[i]);
            bypass = 1'b0;
            e = sb.pop_front();
            total++;
            if (vOut !== 1'b1 || dOut !== e || ovf !== 1'b1) begin
                bad++;
                $display("FAIL clr_byp[%0d] vOut=%b dOut=%0d ovf=%b want 1/%0d/1", i, vOut, dOut, ovf, e);
            end
        end
    endtask

    task automatic test_midstream_rst();
        logic signed [DW-1:0] e;
        rst = 1'b1;
        cyc(1'b1, 13'sd1000);
        rst = 1'b0;
        total++;
        if (vOut !== 1'b0 || dOut !== 0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst vOut=%b dOut=%0d ovf=%b want 0/0/0", vOut, dOut, ovf);
        end
        sb.push_back(13'sd0);
        cyc(1'b1, 13'sd500);
        e = sb.pop_front();
        total++;
        if (vOut !== 1'b1 || dOut !== e) begin
            bad++;
            $display("FAIL mid_rst_coef vOut=%b dOut=%0d want 1/%0d", vOut, dOut, e);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_recursion();
        test_saturation();
        test_commit();
        test_clr_bypass();
        test_midstream_rst();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover size=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iir_filter_gen.md
Name: iir_filter_gen

Overview:
- Parametrised direct-form-I IIR filter, the next generation of the fixed 2nd-order iir_filter.
- Generalised in data width, coefficient width and filter order.
- Adds a runtime coefficient write port with shadow/active double-buffering and atomic commit, plus bypass, state clear and a sticky saturation flag.
- Sits between the data_maker/data_sink stimulus blocks (or any valid-strobed producer/consumer) in the filter datapath.

Parameters:
- DW, 13: data width (signed, two's complement).
- CW, 13: coefficient width (signed).
- FRAC, 11: coefficient fractional bits (1.0 = 2^FRAC).
- ORDER, 2: filter order (>=1). Uses ORDER+1 feed-forward taps and ORDER feedback taps.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- vIn  in  1  input sample valid.
- dIn  in  DW  input sample.
- cWe  in  1  coefficient write strobe (to shadow bank).
- cAddr  in  AW=clog2(2*ORDER+1)  coefficient index.
- cData  in  CW  coefficient value.
- cCommit  in  1  copy shadow bank to active bank.
- bypass  in  1  pass-through mode.
- clr  in  1  zero the delay lines.
- dOut  out  DW  filtered sample.
- vOut  out  1  output valid.
- ovf  out  1  sticky saturation flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - dOut=0, vOut=0, ovf=0.
  - x/y delay lines = 0.
  - Shadow and active coefficients = 0, so the output is 0 until a commit.
- Coefficient map:
  - cAddr 0..ORDER -> b0..bORDER.
  - cAddr ORDER+1..2*ORDER -> a1..aORDER.
  - cAddr > 2*ORDER is ignored.
- cWe writes the shadow bank only. It never affects the active bank directly.
- cCommit: active <= shadow at the clock edge (all taps atomically). If cWe and cCommit are in the same cycle, the commit copies the pre-write shadow value; the write lands in the shadow bank.
- Sample processing:
  - Occurs only when vIn=1. Datapath is fully combinational from registered state, output registered. Latency 1: vOut(t+1)=vIn(t), i.e. dOut/vOut valid the cycle after vIn.
  - vOut=0 on every cycle following vIn=0. dOut holds its last value; delay lines hold.
  - Back-to-back vIn every cycle is sustained (throughput 1 sample/cycle).
- Arithmetic:
  - acc = sum(bk*x[n-k], k=0..ORDER) - sum(ak*y[n-k], k=1..ORDER).
  - Full-precision products, ACCW = DW+CW+clog2(2*ORDER+1) bits.
  - y = acc >>> FRAC (arithmetic shift, truncation toward -inf).
  - Saturate to [-2^(DW-1), 2^(DW-1)-1]. Any saturation event sets ovf (sticky until rst).
  - The saturated y is what is stored in the y delay line.
- vIn with cCommit in the same cycle: the sample uses the OLD active coefficients; the new ones apply from the next sample.
- clr=1:
  - Delay lines zeroed at the edge.
  - If vIn=1 in the same cycle, that sample is computed with zero history and its x/y then enter the (cleared) lines as x[n-1]/y[n-1].
  - clr does not touch coefficients, ovf, dOut or vOut.
- bypass=1 with vIn=1:
  - dOut <= dIn. The x and y lines are both shifted with dIn, so leaving bypass continues from a consistent history.
  - No saturation check occurs; vOut timing is unchanged.
- rst has priority over clr, cCommit, cWe and vIn in the same cycle.
- Mid-stream rst: the in-flight sample is dropped (vOut=0 next cycle).

Decomposition:
- Package iir_gen_pkg holds:
  - clog2 function and ACCW/AW derivation.
  - Saturate-and-flag function (acc, DW) -> (y, sat).
  - Coefficient index constants B_BASE=0, A_BASE=ORDER+1.
- Sub-module iir_coef_bank holds the shadow and active register arrays.
  - Inputs: cWe, cAddr, cData, cCommit, rst.
  - Outputs: the packed active b and a vectors.
- The top level holds the delay lines, MAC tree, saturation and output registers.

Test Plan (DW=13, CW=13, FRAC=11, ORDER=2; 1.0=2048):
- Reset: hold rst 2 cycles then release, vIn=0 -> dOut=0, vOut=0, ovf=0. Feed x=500 -> dOut=0 (zero coefficients).
- Identity: write b0=2048, commit, then vIn with x=100, -50, 4095 back-to-back -> dOut=100, -50, 4095 on the following cycles with vOut high 3 cycles; ovf=0.
- Recursion/truncation: b0=1024, a1=-1024, commit. Impulse x=2000 then zeros -> dOut=1000, 500, 250, 125, 62, 31.
  - Insert 3 idle cycles mid-sequence: vOut=0, dOut held, sequence resumes unchanged.
- Saturation: b0=4095, commit. x=4000 -> dOut=4095, ovf=1. x=-4096 -> dOut=-4096. x=0 -> dOut=0, ovf stays 1 until rst.
- Commit timing: active b0=2048, shadow b0=1024. cCommit and vIn(x=800) in the same cycle -> dOut=800. Next x=800 -> dOut=400.
- clr/bypass: with the recursive setup mid-decay (y[n-1]=500), clr with vIn(x=0) -> dOut=0. Then bypass=1, x=-7 -> dOut=-7, ovf unchanged.
